// File: rtl/spi_adc_responder_pkg.sv
// Shared definitions for the lock-in front-end SPI ADC responder.
// Frame length matches the SPI master in the lock-in top level.
package spi_adc_responder_pkg;

  localparam int SPI_WIDTH = 16;
  localparam int SPI_SYNC  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/spi_adc_responder_sync_edge.sv
// Multi-flop synchronizer with rise/fall detection on the synced value.
// The reset value is a parameter so idle lines come up without edges.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sr;
  logic              prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr   <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sr[i] <= sr[i-1];
      end
      prev <= sr[STAGES-1];
    end
  end

  assign q    = sr[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_adc_responder.sv
// SPI mode-0 slave standing in for the lock-in ADC: shifts a queued
// sample out on miso and captures the concurrent mosi word.
module spi_adc_responder
  import spi_adc_responder_pkg::*;
#(
  parameter int WIDTH       = SPI_WIDTH,
  parameter int SYNC_STAGES = SPI_SYNC
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ss,
  input  logic             sck,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             underrun,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int FL = SYNC_STAGES + 1;

  logic ss_q, ss_rise, ss_fall;
  logic sck_q, sck_rise, sck_fall;
  logic mosi_q, mosi_rise_unused, mosi_fall_unused;

  state_t           state;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] rx_shift;
  logic [WIDTH-1:0] last_tx;
  logic [WIDTH-1:0] hold_reg;
  logic             hold_full;
  logic [CW-1:0]    bit_cnt;
  logic             rx_done;
  logic [FL-1:0]    flush;
  logic             armed;
  logic             start;
  logic             take;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .clk  (CLK),
    .rst  (RST),
    .d    (ss),
    .q    (ss_q),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk  (CLK),
    .rst  (RST),
    .d    (sck),
    .q    (sck_q),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk  (CLK),
    .rst  (RST),
    .d    (mosi),
    .q    (mosi_q),
    .rise (mosi_rise_unused),
    .fall (mosi_fall_unused)
  );

  // A start needs ss genuinely seen high since reset, not the reset value.
  assign start        = (state == ST_IDLE) && ss_fall && armed;
  assign take         = sample_valid && !hold_full;
  assign sample_ready = !hold_full;
  assign busy         = (state != ST_IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      tx_shift  <= '0;
      rx_shift  <= '0;
      last_tx   <= '0;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      bit_cnt   <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      rx_valid  <= 1'b0;
      underrun  <= 1'b0;
      miso      <= 1'b0;
      flush     <= '0;
      armed     <= 1'b0;
    end else begin
      flush    <= {flush[FL-2:0], 1'b1};
      rx_done  <= 1'b0;
      rx_valid <= rx_done;
      underrun <= 1'b0;
      if (flush[FL-1] && ss_q && sck_q == 1'b0)
        armed <= 1'b1;
      else if (flush[FL-1] && ss_q)
        armed <= 1'b1;

      unique case (state)
        ST_IDLE: begin
          miso <= 1'b0;
          if (start) begin
            state   <= ST_ACTIVE;
            bit_cnt <= '0;
            if (hold_full) begin
              tx_shift <= hold_reg;
              last_tx  <= hold_reg;
              miso     <= hold_reg[WIDTH-1];
            end else begin
              tx_shift <= last_tx;
              miso     <= last_tx[WIDTH-1];
              underrun <= 1'b1;
            end
          end
        end
        ST_ACTIVE: begin
          if (ss_rise) begin
            state <= ST_IDLE;
            miso  <= 1'b0;
          end else if (sck_rise) begin
            rx_shift <= {rx_shift[WIDTH-2:0], mosi_q};
            bit_cnt  <= bit_cnt + CW'(1);
            if (bit_cnt == CW'(WIDTH - 1)) begin
              rx_data <= {rx_shift[WIDTH-2:0], mosi_q};
              rx_done <= 1'b1;
              state   <= ST_DONE;
              miso    <= 1'b0;
            end
          end else if (sck_fall) begin
            tx_shift <= tx_shift << 1;
            miso     <= tx_shift[WIDTH-2];
          end
        end
        ST_DONE: begin
          miso <= 1'b0;
          if (ss_rise)
            state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          miso  <= 1'b0;
        end
      endcase

      // Frame start empties the register; a same-cycle offer refills it.
      if (start)
        hold_full <= 1'b0;
      if (take) begin
        hold_reg  <= sample_in;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: doc/spi_adc_responder.md
# spi_adc_responder

SPI slave that emulates the lock-in front-end ADC on the far end of the SPI master in `top`. It answers that master's `ss`/`sck`/`mosi` frames by shifting a parallel sample word out on `miso`, and captures the concurrent `mosi` word. It runs entirely on the system clock `CLK`, oversampling the SPI lines. Its uses are a synthesizable stand-in for the ADC (hardware-in-loop tests, second board) and the slave model in benches for `top`.

## Interface
Parameters:
- `WIDTH`, 16, SPI frame length in bits; also the sample and receive word width.
- `SYNC_STAGES`, 2, flip-flop synchronizer depth on `ss`, `sck` and `mosi`.

Ports:
- `CLK`  in  1  system clock; all logic sits on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `ss`  in  1  SPI slave select, active low, asynchronous to `CLK`.
- `sck`  in  1  SPI clock, CPOL=0, asynchronous to `CLK`.
- `mosi`  in  1  master-to-slave data.
- `miso`  out  1  slave-to-master data.
- `sample_in`  in  WIDTH  next word to transmit.
- `sample_valid`  in  1  `sample_in` is offered.
- `sample_ready`  out  1  the holding register is empty.
- `rx_data`  out  WIDTH  last complete word received on `mosi`.
- `rx_valid`  out  1  one-cycle pulse; `rx_data` was updated.
- `underrun`  out  1  one-cycle pulse; a frame started with the holding register empty.
- `busy`  out  1  a frame is in progress (state ≠ IDLE).

## Operation
- SPI mode 0, MSB first.
  - Master samples `miso` on the `sck` rising edge.
  - Slave updates `miso` after the `sck` falling edge.
- All three SPI inputs pass through `SYNC_STAGES` synchronizers.
  - Edges are detected by comparing the synced value with a one-cycle-delayed copy.
  - Only the synced signals are used internally.
- Holding register, one entry, with a `hold_full` flag:
  - Handshake: a transfer happens when `sample_valid && sample_ready`, with `sample_ready = !hold_full`.
  - The frame-start load clears `hold_full`.
  - If a handshake and a frame start fall on the same cycle, the frame takes the old content or the underrun path, and the new word fills the register.
- State machine IDLE → ACTIVE → DONE → IDLE:
  - **IDLE:** `miso`=0. A synced `ss` falling edge loads `tx_shift` and enters ACTIVE.
    - If `hold_full`: `tx_shift` ← holding register, and `last_tx` ← the same word.
    - Otherwise: `tx_shift` ← `last_tx` and `underrun` pulses.
  - **ACTIVE:** `miso` = `tx_shift[WIDTH-1]`.
    - Each synced `sck` rise: `rx_shift` ← {`rx_shift[WIDTH-2:0]`, `mosi`}, and `bit_cnt` increments.
    - Each synced `sck` fall: `tx_shift` shifts left with 0 fill.
    - When `bit_cnt` reaches WIDTH on a rise: `rx_data` ← the new `rx_shift`, `rx_valid` pulses on the next cycle, and the state goes to DONE.
  - **DONE:** `miso`=0. Extra `sck` edges are ignored. A synced `ss` rise goes to IDLE.
  - **Abort:** a synced `ss` rise in ACTIVE returns to IDLE.
    - No `rx_valid` pulse; `rx_data` is unchanged.
    - The loaded word counts as consumed.
- `bit_cnt` width is `$clog2(WIDTH+1)` and it clears on every frame start.
- `ss` falling in DONE is impossible, because `ss` must rise first.
- If `ss` rises and falls within one synced sample, the edge is missed. This is legal only because of the `sck` constraint under Timing.

## Timing
- Constraint: the `sck` high and low phases and the `ss` high time must each last at least `SYNC_STAGES`+2 `CLK` cycles. That gives `sck` ≤ `CLK`/8 at `SYNC_STAGES`=2.
- `ss` low → first MSB on `miso`: `SYNC_STAGES`+1 cycles.
- `sck` fall → next bit on `miso`: `SYNC_STAGES`+1 cycles. This must be shorter than the `sck` low phase.
- Last `sck` rise → `rx_valid`: `SYNC_STAGES`+2 cycles.
- Reset values:
  - Outputs: `miso`=0, `sample_ready`=1, `rx_data`=0, `rx_valid`=0, `underrun`=0, `busy`=0.
  - Internal: `last_tx`=0, `hold_full`=0, state=IDLE.
  - Synchronizers reset to `ss`=1, `sck`=0, `mosi`=0. This prevents a spurious `ss` falling edge after reset.
- Reset mid-frame: the frame is dropped and the holding content is lost. The slave re-arms on the next `ss` falling edge after `ss` has been seen high.

## Structure
- Shared package or header for the lock-in design (e.g. `spi_defs`):
  - `SPI_WIDTH`=16, matching the master's frame length.
  - State encodings `ST_IDLE`/`ST_ACTIVE`/`ST_DONE`.
- One natural sub-module, `sync_edge`: a `SYNC_STAGES` synchronizer plus rise/fall detection.
  - Reset value is a parameter.
  - Instantiated three times; `mosi` leaves its edge outputs unused.
- Everything else stays flat in `spi_adc_responder`.

## Test plan
- **Basic frame:** after reset, offer 16'hA5C3. Run a frame at `sck`=`CLK`/8 with `mosi`=16'h1234.
  - `miso` bits read 16'hA5C3.
  - `rx_data`=16'h1234 with exactly one `rx_valid` pulse.
  - `sample_ready` returns to 1.
- **Underrun:** run a second frame with no new sample.
  - `underrun` pulses once.
  - `miso` repeats 16'hA5C3.
  - Right after reset, an empty frame sends 16'h0000.
- **Back-pressure:** offer 16'h0001, then hold `sample_valid` with 16'h0002.
  - `sample_ready` stays 0 until the frame start.
  - The next two frames send 0001, then 0002.
- **Abort:** raise `ss` after 7 `sck` cycles.
  - No `rx_valid`; `rx_data` is unchanged.
  - The next frame sends the next queued word, with correct alignment.
- **Over-clocking:** send 20 `sck` pulses in one frame.
  - `rx_valid` fires once, after bit 16.
  - `miso`=0 for bits 17–20.
  - Receive data matches the first 16 `mosi` bits.
- **Reset mid-frame:** assert `RST` for 1 cycle at bit 8.
  - All outputs take their reset values.
  - The next full frame after an `ss` high/low cycle passes.
